// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the serial memory-slave controller.
package spi_mem_pkg;

  localparam int       MEM_DEPTH = 32;
  localparam int       ADDR_BITS = 8;
  localparam int       DATA_BITS = 8;
  localparam logic     MODE_WR   = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    SETUP,
    MODE,
    ADDR,
    DATA,
    WAIT_RDY,
    RECV,
    WAIT_DONE,
    FINISH
  } state_e;

endpackage

// File: rtl/spi_mem_ctrl.sv
// Controller that serialises read/write requests to a 32-deep memory slave
// and collects read data, with a timeout on slave handshakes.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 wr,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 cs,
  output logic                 mosi,
  input  logic                 miso,
  input  logic                 ready,
  input  logic                 op_done
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [2:0]           bit_q, bit_d;
  logic [TW-1:0]        to_q, to_d;
  logic                 wr_q, wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rx_q, rx_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 cs_q, cs_d;
  logic                 mosi_q, mosi_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      to_q    <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      to_q    <= to_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    to_d    = to_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // busy_q is still high in an abort's err cycle, so start is gated on it
        if (start && !busy_q) begin
          if (addr >= ADDR_BITS'(MEM_DEPTH)) begin
            err_d = 1'b1;
          end else begin
            state_d = SETUP;
            wr_d    = wr;
            addr_d  = addr;
            wdata_d = wdata;
            to_d    = '0;
          end
        end
      end
      SETUP: state_d = MODE;
      MODE: begin
        state_d = ADDR;
        bit_d   = '0;
      end
      ADDR: begin
        if (bit_q == 3'd7) begin
          bit_d   = '0;
          state_d = (wr_q == MODE_WR) ? DATA : WAIT_RDY;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      DATA: begin
        if (bit_q == 3'd7) begin
          bit_d   = '0;
          state_d = WAIT_DONE;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      WAIT_RDY: begin
        if (op_done) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (ready) begin
          rx_d[0] = miso;
          bit_d   = 3'd1;
          state_d = RECV;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      RECV: begin
        rx_d[bit_q] = miso;
        if (bit_q == 3'd7) begin
          bit_d   = '0;
          state_d = WAIT_DONE;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      WAIT_DONE: begin
        if (op_done) begin
          done_d  = 1'b1;
          state_d = FINISH;
          if (wr_q != MODE_WR) rdata_d = rx_q;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A rejected start never raises busy; an abort keeps it for its err cycle
    busy_d = (state_d != IDLE) || done_d || (err_d && (state_q != IDLE));

    // Line outputs are registered from the next state so they align with it
    cs_d   = 1'b1;
    mosi_d = 1'b0;
    case (state_d)
      SETUP: cs_d = 1'b0;
      MODE: begin
        cs_d   = 1'b0;
        mosi_d = wr_d;
      end
      ADDR: begin
        cs_d   = 1'b0;
        mosi_d = addr_d[bit_d];
      end
      DATA: begin
        cs_d   = 1'b0;
        mosi_d = wdata_d[bit_d];
      end
      default: ;
    endcase
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign cs    = cs_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Scoreboard bench: stimulus queues expected responses and mosi frames,
// monitors compare them against a behavioural memory slave run.
module tb_spi_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, wr = 1'b0;
  logic [7:0] addr = '0, wdata = '0;
  logic       busy, done, err, cs, mosi;
  logic [7:0] rdata;
  logic       miso = 1'b0, ready = 1'b0, op_done = 1'b0;

  always #5 clk = ~clk;

  spi_mem_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .cs(cs), .mosi(mosi),
    .miso(miso), .ready(ready), .op_done(op_done)
  );

  typedef struct {
    logic       is_err;
    logic       chk_rd;
    logic [7:0] rd;
    logic       chk_lat;
    int         lat;
  } exp_t;

  typedef struct {
    int          len;
    logic [17:0] bits;
  } frm_t;

  exp_t sbq[$];
  frm_t fq[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, wrdy_cyc = 0;
  logic stub = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic frm_t mkf(input int len, input logic w, input logic [7:0] a,
                               input logic [7:0] d);
    frm_t f;
    f.len  = len;
    f.bits = {d, a, w, 1'b0};
    return f;
  endfunction

  function automatic exp_t rsp(input logic e, input logic c, input logic [7:0] r,
                               input logic cl, input int l);
    exp_t x;
    x.is_err = e; x.chk_rd = c; x.rd = r; x.chk_lat = cl; x.lat = l;
    return x;
  endfunction

  function automatic logic [17:0] lmask(input int len);
    logic [18:0] m;
    m = (19'd1 << len) - 19'd1;
    return m[17:0];
  endfunction

  // Behavioural memory slave: decodes the mosi frame, answers after 2 cycles
  logic [7:0]  mem[0:31];
  logic [17:0] sbits = '0;
  int          slen = 0;
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (cs === 1'b0) begin
        if (slen < 18) sbits[slen] = mosi;
        slen++;
      end else if (slen > 0) begin
        if (slen == 18 && sbits[1]) begin
          mem[sbits[6:2]] = sbits[17:10];
          repeat (2) @(negedge clk);
          op_done = 1'b1;
          @(negedge clk);
          op_done = 1'b0;
        end else if (slen == 10 && !sbits[1] && !stub) begin
          logic [7:0] v;
          v = mem[sbits[6:2]];
          repeat (2) @(negedge clk);
          ready = 1'b1;
          miso  = v[0];
          @(negedge clk);
          ready = 1'b0;
          for (int i = 1; i < 8; i++) begin
            miso = v[i];
            @(negedge clk);
          end
          miso    = 1'b0;
          op_done = 1'b1;
          @(negedge clk);
          op_done = 1'b0;
        end
        slen  = 0;
        sbits = '0;
      end
    end
  end

  // Monitor: mosi frames on cs release, done/err pulses against the scoreboard
  logic [17:0] cap_bits = '0;
  int          cap_len = 0;
  always @(negedge clk) begin
    frm_t f;
    exp_t e;
    cyc++;
    if (cs === 1'b1 && mosi !== 1'b0) chk("mosi_idle_low", int'(mosi), 0);
    if (cs === 1'b0) begin
      if (cap_len < 18) cap_bits[cap_len] = mosi;
      cap_len++;
    end else if (cs === 1'b1 && cap_len > 0) begin
      wrdy_cyc = cyc;
      if (fq.size() == 0) chk("frame_unexpected", cap_len, 0);
      else begin
        f = fq.pop_front();
        chk("frame_len", cap_len, f.len);
        chk("frame_bits", int'(cap_bits & lmask(f.len)), int'(f.bits & lmask(f.len)));
      end
      cap_len  = 0;
      cap_bits = '0;
    end
    if (done === 1'b1 || err === 1'b1) begin
      chk("done_err_excl", int'(done & err), 0);
      if (sbq.size() == 0) chk("resp_unexpected", int'({done, err}), 0);
      else begin
        e = sbq.pop_front();
        chk("resp_kind_err", int'(err), int'(e.is_err));
        if (e.chk_rd)  chk("rdata", int'(rdata), int'(e.rd));
        if (e.chk_lat) chk("err_latency", cyc - wrdy_cyc, e.lat);
      end
    end
  end

  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    start = 1'b1; wr = w; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("busy_timeout", int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int         n;
    repeat (3) @(negedge clk);
    chk("rst_cs", int'(cs), 1);
    chk("rst_mosi", int'(mosi), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_rdata", int'(rdata), 0);
    rst = 1'b0;

    // Write addr 5 = A5: frame 0, 1, 1010_0000, 1010_0101 (LSB first)
    fq.push_back('{len: 18, bits: 18'b10100101_00000101_10});
    sbq.push_back(rsp(1'b0, 1'b0, 8'h00, 1'b0, 0));
    issue(1'b1, 8'd5, 8'hA5);
    chk("busy_after_start", int'(busy), 1);
    wait_idle();

    // Read addr 5: frame 0, 0, 1010_0000
    fq.push_back('{len: 10, bits: 18'b00000101_00});
    sbq.push_back(rsp(1'b0, 1'b1, 8'hA5, 1'b0, 0));
    issue(1'b0, 8'd5, 8'h00);
    wait_idle();
    chk("rdata_hold", int'(rdata), 8'hA5);

    // Out-of-range address: err the next cycle, no select, no busy
    sbq.push_back(rsp(1'b1, 1'b0, 8'h00, 1'b0, 0));
    issue(1'b1, 8'h20, 8'h77);
    chk("reject_err", int'(err), 1);
    chk("reject_cs", int'(cs), 1);
    chk("reject_busy", int'(busy), 0);
    @(negedge clk);
    chk("reject_err_once", int'(err), 0);

    // Slave never ready: err 16 cycles after WAIT_RDY entry, rdata kept
    stub = 1'b1;
    fq.push_back(mkf(10, 1'b0, 8'd7, 8'h00));
    sbq.push_back(rsp(1'b1, 1'b1, 8'hA5, 1'b1, 16));
    issue(1'b0, 8'd7, 8'h00);
    n = 0;
    while (err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("timeout_err_seen", int'(err), 1);
    chk("abort_busy_in_err", int'(busy), 1);
    // Start during the abort's err cycle must be ignored
    start = 1'b1; wr = 1'b1; addr = 8'd2; wdata = 8'h11;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_clear", int'(busy), 0);
    stub = 1'b0;
    repeat (3) @(negedge clk);
    chk("ignored_start_cs", int'(cs), 1);

    // Reset during DATA bit 3: 14 bits shifted, then abort without pulses
    fq.push_back(mkf(14, 1'b1, 8'd9, 8'h5A));
    issue(1'b1, 8'd9, 8'h5A);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cs", int'(cs), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_rdata", int'(rdata), 0);
    rst = 1'b0;
    fq.push_back(mkf(18, 1'b1, 8'd1, 8'h3C));
    sbq.push_back(rsp(1'b0, 1'b0, 8'h00, 1'b0, 0));
    issue(1'b1, 8'd1, 8'h3C);
    wait_idle();
    fq.push_back(mkf(10, 1'b0, 8'd1, 8'h00));
    sbq.push_back(rsp(1'b0, 1'b1, 8'h3C, 1'b0, 0));
    issue(1'b0, 8'd1, 8'h00);
    wait_idle();

    // Fill all 32 locations with addr^FF, poking start while busy, then read back
    for (int a = 0; a < 32; a++) begin
      d = 8'(a) ^ 8'hFF;
      fq.push_back(mkf(18, 1'b1, 8'(a), d));
      sbq.push_back(rsp(1'b0, 1'b0, 8'h00, 1'b0, 0));
      issue(1'b1, 8'(a), d);
      repeat (2) @(negedge clk);
      start = 1'b1; wr = 1'b1; addr = 8'(a); wdata = 8'h00;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
    end
    for (int a = 0; a < 32; a++) begin
      fq.push_back(mkf(10, 1'b0, 8'(a), 8'h00));
      sbq.push_back(rsp(1'b0, 1'b1, 8'(a) ^ 8'hFF, 1'b0, 0));
      issue(1'b0, 8'(a), 8'h00);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    chk("resp_queue_drained", sbq.size(), 0);
    chk("frame_queue_drained", fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_ctrl.md
SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 64, max cycles waited for slave ready/op_done before abort.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request pulse; accepted only when busy=0.
REQ-005 wr  input  1  1=write, 0=read; sampled with start.
REQ-006 addr  input  8  memory address; sampled with start.
REQ-007 wdata  input  8  write data; sampled with start.
REQ-008 busy  output  1  high from cycle after accepted start until done/err pulse cycle inclusive.
REQ-009 done  output  1  one-cycle pulse on successful completion.
REQ-010 err  output  1  one-cycle pulse on rejected or aborted request.
REQ-011 rdata  output  8  read result; valid with done, held until next read completes.
REQ-012 cs  output  1  slave select to memory slave, active-low, registered.
REQ-013 mosi  output  1  serial data to slave, registered.
REQ-014 miso  input  1  serial data from slave.
REQ-015 ready  input  1  slave read-data-valid flag.
REQ-016 op_done  input  1  slave completion pulse.

Function
REQ-017 States SHALL be IDLE, SETUP, MODE, ADDR, DATA, WAIT_RDY, RECV, WAIT_DONE, FINISH.
REQ-018 IDLE: on start with addr>31, SHALL pulse err next cycle, leave cs=1, and stay in IDLE (slave depth 32).
REQ-019 IDLE: on start with addr<=31, SHALL latch wr/addr/wdata, go SETUP; start while busy SHALL be ignored.
REQ-020 SETUP: cs=0, mosi=0 for exactly one cycle.
REQ-021 MODE: cs=0, mosi=wr for one cycle.
REQ-022 ADDR: cs=0, mosi=addr[0]..addr[7], LSB first, one bit per cycle, 8 cycles.
REQ-023 Write: after ADDR, DATA drives wdata[0]..wdata[7] LSB first, 8 cycles, then WAIT_DONE.
REQ-024 Read: after ADDR, go WAIT_RDY.
REQ-025 cs SHALL return to 1 in the cycle after the last mosi bit and stay 1 until next SETUP; mosi=0 whenever cs=1.
REQ-026 WAIT_RDY: on first cycle ready=1, SHALL capture miso as rdata bit0 and enter RECV.
REQ-027 RECV: SHALL capture miso into bits 1..7 on the 7 following cycles, then WAIT_DONE.
REQ-028 WAIT_DONE: on op_done=1, go FINISH; FINISH pulses done (rdata updated for reads only), returns IDLE.
REQ-029 Timeout counter SHALL clear on SETUP entry, count in WAIT_RDY and WAIT_DONE; reaching TIMEOUT SHALL pulse err, return IDLE, leave rdata unchanged.
REQ-030 done and err SHALL never assert in the same cycle; each request yields exactly one of them.
REQ-031 op_done seen in WAIT_RDY SHALL be treated as protocol error: err pulse, return IDLE.

Reset
REQ-032 On rst: state=IDLE, cs=1, mosi=0, busy=0, done=0, err=0, rdata=0, counters=0.
REQ-033 rst mid-transaction SHALL abort with no done/err pulse; cs=1 on the cycle after rst sampled.

Structure
REQ-034 Package spi_mem_pkg SHALL hold the state enum, MEM_DEPTH=32, ADDR_BITS=8, DATA_BITS=8, MODE_WR=1.
REQ-035 Single module; bit counter and timeout counter inline, no sub-module.

Verification
REQ-036 Write addr=5 wdata=0xA5 with spi_mem slave -> mosi after SETUP: 1, 1010_0000, 1010_0101 (LSB first); done pulse; busy cleared.
REQ-037 Read addr=5 after REQ-036 -> mosi after SETUP: 0, 1010_0000; rdata=0xA5 with done; cs=1 throughout RECV.
REQ-038 start with addr=0x20 -> err pulse one cycle later, cs stays 1, no mosi toggle.
REQ-039 Stub slave never asserts ready, TIMEOUT=16 -> err exactly 16 cycles after WAIT_RDY entry; rdata unchanged.
REQ-040 rst asserted during DATA bit 3 -> cs=1, busy=0 next cycle; no done/err; subsequent write addr=1 data=0x3C completes.
REQ-041 Back-to-back writes addr 0..31 data=addr^0xFF, then reads -> all match; start pulses during busy ignored.
